// File: rtl/case_stream_ctrl.sv
// case_stream_ctrl
//   Streaming sequencer for the ASCII case-conversion datapath. Accepts
//   NUL-terminated byte strings on a valid/ready input. Each string gets a case
//   mode (pass/upper/lower/toggle), which is applied through one output
//   register. After each string the block reports the string length and the
//   number of converted characters.
//
//   Optional feature: define CASE_SKID_EN to insert a 2-entry skid buffer ahead
//   of the output register. With it, in_ready becomes a flop and no longer
//   depends combinationally on out_ready. Without it (default), in_ready is
//   combinational.
//
// Parameters
//   CNT_W         width of the saturating str_len / conv_cnt counters
//   MODE_DEFAULT  mode_reg value after reset (2'b01 = upper)
//
// Ports
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   cfg_mode    00 pass, 01 upper, 10 lower, 11 toggle
//   cfg_load    write cfg_mode into mode_reg this cycle
//   in_valid    input byte valid
//   in_data     input byte (8'h00 terminates a string)
//   in_ready    input byte accepted when in_valid && in_ready
//   out_valid   output byte valid
//   out_data    converted output byte
//   out_ready   output byte consumed when out_valid && out_ready
//   str_done    one-cycle pulse after the terminating NUL is delivered
//   str_len     non-NUL byte count of the last completed string
//   conv_cnt    count of bytes changed by the mapping in the last string
//   busy        state != IDLE || out_valid
module case_stream_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter logic [1:0]  MODE_DEFAULT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_load,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             str_done,
  output logic [CNT_W-1:0] str_len,
  output logic [CNT_W-1:0] conv_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [1:0]       mode_reg;
  logic [1:0]       active_mode;
  logic [CNT_W-1:0] run_len;
  logic [CNT_W-1:0] run_conv;
  logic             out_last;   // byte held in the output register is the NUL

  logic [1:0] byte_mode;
  logic [7:0] in_conv;
  logic       in_nul;
  logic       in_changed;
  logic       accept;
  logic       last_hs;

  function automatic logic [7:0] case_map(input logic [1:0] m, input logic [7:0] b);
    logic is_lo;
    logic is_up;
    is_lo    = (b >= 8'h61) && (b <= 8'h7A);
    is_up    = (b >= 8'h41) && (b <= 8'h5A);
    case_map = b;
    if (m[0] && is_lo) case_map = b - 8'h20;
    if (m[1] && is_up) case_map = b + 8'h20;
  endfunction

  // The first byte of a string picks its mode. A cfg_load in that same cycle
  // is bypassed straight through, so the new mode is used for this string.
  always_comb begin
    if (state == IDLE) byte_mode = cfg_load ? cfg_mode : mode_reg;
    else               byte_mode = active_mode;
  end

  assign in_conv    = case_map(byte_mode, in_data);
  assign in_nul     = (in_data == 8'h00);
  assign in_changed = (in_conv != in_data);
  assign accept     = in_valid && in_ready;
  assign last_hs    = out_valid && out_ready && out_last;
  assign busy       = (state != IDLE) || out_valid;

  // Sequencer FSM, mode latching and string counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_reg    <= MODE_DEFAULT;
      active_mode <= MODE_DEFAULT;
      run_len     <= '0;
      run_conv    <= '0;
      str_done    <= 1'b0;
      str_len     <= '0;
      conv_cnt    <= '0;
    end else begin
      str_done <= 1'b0;
      if (cfg_load) mode_reg <= cfg_mode;

      case (state)
        IDLE: begin
          if (accept) begin
            active_mode <= byte_mode;
            state       <= in_nul ? DRAIN : ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept && in_nul) state <= DRAIN;
        end
        DRAIN: begin
          if (last_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // No byte is accepted while draining, so these two branches never compete.
      if (last_hs) begin
        str_done <= 1'b1;
        str_len  <= run_len;
        conv_cnt <= run_conv;
        run_len  <= '0;
        run_conv <= '0;
      end else if (accept && !in_nul) begin
        if (run_len != '1) run_len <= run_len + CNT_ONE;
        if (in_changed && (run_conv != '1)) run_conv <= run_conv + CNT_ONE;
      end
    end
  end

`ifdef CASE_SKID_EN
  // Skid path: the output register is refilled from the buffer head when the
  // buffer is non-empty. Otherwise it loads the input directly, which keeps
  // the unstalled latency at one cycle.
  logic [1:0][8:0] skid_q;
  logic [1:0]      skid_cnt;
  logic [1:0]      skid_cnt_next;
  logic [1:0]      push_idx;
  logic            out_free;
  logic            pop;
  logic            bypass;
  logic            push;
  logic            drain_next;

  always_comb begin
    out_free   = !out_valid || out_ready;
    pop        = out_free && (skid_cnt != 2'd0);
    bypass     = out_free && (skid_cnt == 2'd0) && accept;
    push       = accept && !bypass;
    push_idx   = pop ? (skid_cnt - 2'd1) : skid_cnt;
    drain_next = ((state == DRAIN) && !last_hs) || (accept && in_nul);
    case ({push, pop})
      2'b10:   skid_cnt_next = skid_cnt + 2'd1;
      2'b01:   skid_cnt_next = skid_cnt - 2'd1;
      default: skid_cnt_next = skid_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      skid_q    <= '0;
      skid_cnt  <= '0;
      in_ready  <= 1'b1;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= skid_q[0][7:0];
        out_last  <= skid_q[0][8];
      end else if (bypass) begin
        out_valid <= 1'b1;
        out_data  <= in_conv;
        out_last  <= in_nul;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Shift first; a simultaneous push into the vacated slot overrides it.
      if (pop) skid_q[0] <= skid_q[1];
      if (push) skid_q[push_idx[0]] <= {in_nul, in_conv};
      skid_cnt <= skid_cnt_next;
      in_ready <= (skid_cnt_next != 2'd2) && !drain_next;
    end
  end
`else
  assign in_ready = (state != DRAIN) && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_conv;
      out_last  <= in_nul;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
